// File: rtl/data_window_sequencer.sv
// Read-side sequencer for the 5-tap data RAM. It issues one RAM read per window centre,
// zero-pads the taps outside [0, Len_eff-1] and presents each window over valid/ready.
module data_window_sequencer #(
    parameter int Bit_width          = 8,
    parameter int Nr_depth           = 512,
    parameter int Depth_counter_bits = 9,
    parameter int Stride             = 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic [Depth_counter_bits:0]   Length,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Read_en,
    output logic [Depth_counter_bits-1:0] Address_depth_read,
    input  logic [Bit_width-1:0]          Read_data_in_0,
    input  logic [Bit_width-1:0]          Read_data_in_1,
    input  logic [Bit_width-1:0]          Read_data_in_2,
    input  logic [Bit_width-1:0]          Read_data_in_3,
    input  logic [Bit_width-1:0]          Read_data_in_4,
    output logic                          Window_valid,
    input  logic                          Window_ready,
    output logic [Bit_width-1:0]          Window_data_0,
    output logic [Bit_width-1:0]          Window_data_1,
    output logic [Bit_width-1:0]          Window_data_2,
    output logic [Bit_width-1:0]          Window_data_3,
    output logic [Bit_width-1:0]          Window_data_4,
    output logic [Depth_counter_bits-1:0] Window_index,
    output logic                          Window_last,
    output logic [1:0]                    State_dbg
);

    localparam int DCB = Depth_counter_bits;
    localparam logic [DCB:0]   LEN_MAX  = (DCB + 1)'(Nr_depth);
    localparam logic [DCB-1:0] STRIDE_W = DCB'(Stride);
    localparam logic [DCB+1:0] STRIDE_X = (DCB + 2)'(Stride);

    // Handshake: a window transfers on a rising Clk edge where Window_valid && Window_ready.
    // Window_valid, once raised, stays high with every Window_* output frozen until that edge.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_PRESENT = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DCB:0]   len_q;
    logic [DCB:0]   len_clamped;
    logic [DCB-1:0] centre_q, centre_d;
    logic           accept;
    logic           advance;
    logic           handshake;

    logic signed [DCB+1:0] tap_addr [5];
    logic [Bit_width-1:0]  tap_raw  [5];
    logic [Bit_width-1:0]  tap_pad  [5];

    assign len_clamped = (Length > LEN_MAX) ? LEN_MAX : Length;
    assign handshake   = Window_valid && Window_ready;
    assign State_dbg   = state_q;

    assign tap_raw[0] = Read_data_in_0;
    assign tap_raw[1] = Read_data_in_1;
    assign tap_raw[2] = Read_data_in_2;
    assign tap_raw[3] = Read_data_in_3;
    assign tap_raw[4] = Read_data_in_4;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (len_clamped != '0) begin
                        accept  = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (handshake) begin
                    if (Window_last) begin
                        state_d = S_FINISH;
                    end else begin
                        advance = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        centre_d = centre_q;
        if (accept) begin
            centre_d = '0;
        end else if (advance) begin
            centre_d = centre_q + STRIDE_W;
        end
    end

    // Tap addresses are signed and one bit wider than needed so both edges of the
    // sample range are masked here; the RAM itself would silently wrap.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            tap_addr[k] = $signed({2'b00, centre_q}) + $signed((DCB + 2)'(k - 2));
            if (!tap_addr[k][DCB+1] && (tap_addr[k] < $signed({1'b0, len_q}))) begin
                tap_pad[k] = tap_raw[k];
            end else begin
                tap_pad[k] = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Busy               <= 1'b0;
            Done               <= 1'b0;
            Read_en            <= 1'b0;
            Address_depth_read <= '0;
            Window_valid       <= 1'b0;
            Window_data_0      <= '0;
            Window_data_1      <= '0;
            Window_data_2      <= '0;
            Window_data_3      <= '0;
            Window_data_4      <= '0;
            Window_index       <= '0;
            Window_last        <= 1'b0;
            len_q              <= '0;
            centre_q           <= '0;
        end else begin
            Busy         <= (state_d == S_ISSUE) || (state_d == S_PRESENT);
            Done         <= (state_d == S_FINISH);
            Read_en      <= (state_d == S_ISSUE);
            Window_valid <= (state_d == S_PRESENT);
            centre_q     <= centre_d;
            if (accept) begin
                len_q <= len_clamped;
            end
            if (state_d == S_ISSUE) begin
                Address_depth_read <= centre_d;
            end
            // Taps from the ISSUE-cycle read are stable at this edge.
            if (state_q == S_ISSUE) begin
                Window_data_0 <= tap_pad[0];
                Window_data_1 <= tap_pad[1];
                Window_data_2 <= tap_pad[2];
                Window_data_3 <= tap_pad[3];
                Window_data_4 <= tap_pad[4];
                Window_index  <= centre_q;
                Window_last   <= (({2'b00, centre_q} + STRIDE_X) >= {1'b0, len_q});
            end
        end
    end

endmodule

// File: tb/tb_data_window_sequencer.sv
// Bench for data_window_sequencer: two instances (Stride 1 and 2) behind one RAM model,
// a window reference model feeding an expected queue, and a negedge monitor that checks it.
module tb_data_window_sequencer;

    localparam int W     = 8;
    localparam int DCB   = 9;
    localparam int DEPTH = 512;
    localparam int NI    = 2;
    localparam int EW    = DCB + 1 + 5 * W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             window_ready = 1'b1;
    logic [DCB:0]     length = '0;
    int               sel = 0;

    logic [NI-1:0]                busy, done, read_en, wv, wlast;
    logic [NI-1:0][DCB-1:0]       addr, widx;
    logic [NI-1:0][4:0][W-1:0]    rd, wd;
    logic [NI-1:0][1:0]           dbg;

    logic [W-1:0]  ram [DEPTH];
    logic [EW-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt    [NI];
    int reads     [NI];
    int done_cnt  [NI];
    int stall_cnt [NI];
    bit done_due  [NI];
    logic [EW-1:0] last_win  [NI];
    logic [EW-1:0] first_win [NI];
    bit zero_pass = 1'b0;
    int ready_mode = 0;
    int stall_idx = 0;
    int stall_left = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_window_sequencer #(
            .Bit_width(W), .Nr_depth(DEPTH), .Depth_counter_bits(DCB), .Stride(g + 1)
        ) u_dut (
            .Clk(clk), .Reset(reset), .Start(start && (sel == g)), .Length(length),
            .Busy(busy[g]), .Done(done[g]), .Read_en(read_en[g]),
            .Address_depth_read(addr[g]),
            .Read_data_in_0(rd[g][0]), .Read_data_in_1(rd[g][1]), .Read_data_in_2(rd[g][2]),
            .Read_data_in_3(rd[g][3]), .Read_data_in_4(rd[g][4]),
            .Window_valid(wv[g]), .Window_ready(window_ready),
            .Window_data_0(wd[g][0]), .Window_data_1(wd[g][1]), .Window_data_2(wd[g][2]),
            .Window_data_3(wd[g][3]), .Window_data_4(wd[g][4]),
            .Window_index(widx[g]), .Window_last(wlast[g]), .State_dbg(dbg[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input int idx, input bit last,
                                           input int t0, input int t1, input int t2,
                                           input int t3, input int t4);
        logic [4:0][W-1:0] t;
        t[0] = W'(t0); t[1] = W'(t1); t[2] = W'(t2); t[3] = W'(t3); t[4] = W'(t4);
        return {DCB'(idx), last, t};
    endfunction

    // RAM model: samples the centre on the negedge of a read cycle, wraps like real RAM,
    // and scrambles its outputs whenever no read is in progress.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            for (int k = 0; k < 5; k++) begin
                if (read_en[g] === 1'b1) rd[g][k] <= ram[(int'(addr[g]) + k - 2 + DEPTH) % DEPTH];
                else rd[g][k] <= W'($urandom);
            end
            if (read_en[g] === 1'b1) reads[g]++;
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            logic [EW-1:0] act;
            if (done_due[g]) begin
                check("done_after_last", done[g], 1);
                done_due[g] = 1'b0;
            end else if (done[g] === 1'b1 && !zero_pass) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got 1 expected 0 (dut %0d)", g);
            end
            if (done[g] === 1'b1) done_cnt[g]++;
            if (read_en[g] === 1'b1) check("read_during_window", wv[g], 0);
            if (wv[g] === 1'b1) begin
                act = {widx[g], wlast[g], wd[g]};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_window: got 0x%0h expected none", act);
                end else begin
                    check("window", act, exp_q[0]);
                    if (window_ready) begin
                        if (exp_q[0][5*W]) done_due[g] = 1'b1;
                        void'(exp_q.pop_front());
                        hs_cnt[g]++;
                        last_win[g] = act;
                        if (widx[g] == '0) first_win[g] = act;
                    end else begin
                        stall_cnt[g]++;
                    end
                end
            end
        end
    end

    // ready driver
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: window_ready = 1'b1;
            1: begin
                if (wv[sel] && int'(widx[sel]) == stall_idx && stall_left > 0) begin
                    window_ready = 1'b0;
                    stall_left--;
                end else begin
                    window_ready = 1'b1;
                end
            end
            default: window_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic load_model(input int s, input int len, output int nwin);
        int st, le;
        st = s + 1;
        le = (len > DEPTH) ? DEPTH : len;
        nwin = (le + st - 1) / st;
        for (int c = 0; c < le; c += st) begin
            logic [4:0][W-1:0] t;
            for (int k = 0; k < 5; k++) begin
                int a;
                a = c + k - 2;
                t[k] = (a >= 0 && a < le) ? ram[a] : '0;
            end
            exp_q.push_back({DCB'(c), (c + st >= le), t});
        end
    endtask

    task automatic run_pass(input int s, input int len, input bit noise);
        int nwin, hs0, rd0, dn0, cyc, le;
        bit got;
        le = (len > DEPTH) ? DEPTH : len;
        sel = s;
        load_model(s, len, nwin);
        hs0 = hs_cnt[s];
        rd0 = reads[s];
        dn0 = done_cnt[s];
        zero_pass = (le == 0);
        @(posedge clk);
        #1;
        length = (DCB + 1)'(len);
        start = 1'b1;
        got = 1'b0;
        for (cyc = 0; cyc < 8 * DEPTH; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (noise) begin
                start = ($urandom_range(0, 4) == 0);
                length = (DCB + 1)'($urandom);
            end
            @(negedge clk);
            if (done[s] === 1'b1) begin
                got = 1'b1;
                break;
            end
            check("busy_in_pass", busy[s], le > 0);
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("busy_at_done", busy[s], 0);
        if (le == 0) check("zero_len_done_latency", cyc, 0);
        repeat (3) @(negedge clk);
        check("window_count", hs_cnt[s] - hs0, nwin);
        check("read_count", reads[s] - rd0, nwin);
        check("done_pulses", done_cnt[s] - dn0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("busy_idle", busy[s], 0);
        zero_pass = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int hs0, dn0, s0, cyc, nwin;
        for (int g = 0; g < NI; g++) begin
            hs_cnt[g] = 0; reads[g] = 0; done_cnt[g] = 0; stall_cnt[g] = 0;
            done_due[g] = 1'b0; last_win[g] = '0; first_win[g] = '0;
        end
        for (int i = 0; i < DEPTH; i++) ram[i] = W'(i + 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++)
            check("reset_outputs", {busy[g], done[g], read_en[g], addr[g], wv[g], wd[g], widx[g], wlast[g]}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // basic pass, Length 8, Stride 1
        run_pass(0, 8, 1'b0);
        check("win0_len8", first_win[0], pack(0, 0, 0, 0, 1, 2, 3));
        check("win7_len8", last_win[0], pack(7, 1, 6, 7, 8, 0, 0));

        // 3-cycle stall on window 2
        s0 = stall_cnt[0];
        stall_idx = 2;
        stall_left = 3;
        ready_mode = 1;
        run_pass(0, 8, 1'b0);
        ready_mode = 0;
        check("stall_cycles", stall_cnt[0] - s0, 3);

        // zero length
        run_pass(0, 0, 1'b0);

        // Stride 2, Length 5
        run_pass(1, 5, 1'b0);
        check("stride2_last", last_win[1], pack(4, 1, 3, 4, 5, 0, 0));

        // reset after the third handshake
        sel = 0;
        load_model(0, 8, nwin);
        hs0 = hs_cnt[0];
        dn0 = done_cnt[0];
        @(posedge clk);
        #1;
        length = 10'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (cyc = 0; cyc < 200 && hs_cnt[0] - hs0 < 3; cyc++) @(posedge clk);
        check("reset_wait_3_handshakes", hs_cnt[0] - hs0 >= 3, 1);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", {busy[0], done[0], read_en[0], addr[0], wv[0], wd[0], widx[0], wlast[0]}, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt[0] - dn0, 0);
        first_win[0] = '0;
        run_pass(0, 8, 1'b0);
        check("restart_win0", first_win[0], pack(0, 0, 0, 0, 1, 2, 3));

        // Length beyond depth is clamped
        for (int i = 0; i < DEPTH; i++) ram[i] = W'(i);
        run_pass(0, 600, 1'b0);
        check("clamped_last", last_win[0], pack(511, 1, 253, 254, 255, 0, 0));

        // randomized passes with random ready, stray Start pulses and Length changes
        ready_mode = 2;
        for (int n = 0; n < 12; n++) begin
            int s, len;
            for (int i = 0; i < DEPTH; i++) ram[i] = W'($urandom);
            s = $urandom_range(0, 1);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
            run_pass(s, len, 1'b1);
        end
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
